// File: rtl/idiv_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; zero-divisor and signed overflow complete in one cycle.
module idiv_seq #(
  parameter int XLEN        = 64,
  parameter bit W_SUPPORTED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            DivStartE,
  input  logic            FlushE,
  input  logic            StallM,
  input  logic [2:0]      Funct3E,
  input  logic            W64E,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  output logic            DivBusyE,
  output logic            DivDoneE,
  output logic [XLEN-1:0] DivResultE
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] x, input logic sgn);
    ext32 = '0;
    ext32[31:0] = x;
    for (int i = 32; i < XLEN; i++) ext32[i] = sgn & x[31];
  endfunction

  function automatic logic [XLEN-1:0] pick(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                           input logic sel_rem, input logic w);
    logic [XLEN-1:0] v;
    v = sel_rem ? r : q;
    return w ? ext32(v[31:0], 1'b1) : v;
  endfunction

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quot_q, rem_q, div_q, result_q;
  logic            neg_q_q, neg_r_q, rem_sel_q, w_q;

  logic            w_op, sgn_op, sign_a, sign_b, div_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] step_quot, step_rem, q_fin, r_fin;
  logic            unused_f3;

  // DIV/DIVU/REM/REMU are told apart by bits [1:0]; bit 2 is always set for this unit.
  assign unused_f3 = Funct3E[2];

  // NOTE: every signal written here gets a value on every path, so no latches are inferred.
  always_comb begin
    w_op     = W_SUPPORTED && (XLEN == 64) && W64E;
    sgn_op   = ~Funct3E[0];
    a_ext    = w_op ? ext32(ForwardedSrcAE[31:0], sgn_op) : ForwardedSrcAE;
    b_ext    = w_op ? ext32(ForwardedSrcBE[31:0], sgn_op) : ForwardedSrcBE;
    sign_a   = sgn_op & a_ext[XLEN-1];
    sign_b   = sgn_op & b_ext[XLEN-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    min_neg  = w_op ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = sgn_op && (a_ext == min_neg) && (b_ext == '1);

    // Restoring step: remainder stays below the divisor, so XLEN bits hold it after the subtract.
    shifted   = {rem_q, quot_q[XLEN-1]};
    diff      = shifted - {1'b0, div_q};
    step_rem  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    step_quot = {quot_q[XLEN-2:0], ~diff[XLEN]};
    q_fin     = neg_q_q ? -step_quot : step_quot;
    r_fin     = neg_r_q ? -step_rem  : step_rem;
  end

  // NOTE: the working registers are cleared on reset too, so no stale operand or result survives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      w_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (DivStartE && !FlushE) begin
          neg_q_q   <= sign_a ^ sign_b;
          neg_r_q   <= sign_a;
          rem_sel_q <= Funct3E[1];
          w_q       <= w_op;
          if (div_zero) begin
            result_q <= pick('1, a_ext, Funct3E[1], w_op);
            state_q  <= DONE;
          end else if (ovf) begin
            result_q <= pick(a_ext, '0, Funct3E[1], w_op);
            state_q  <= DONE;
          end else begin
            // W operands are left-justified so 32 steps consume exactly their 32 bits.
            quot_q  <= w_op ? (mag_a << (XLEN - 32)) : mag_a;
            rem_q   <= '0;
            div_q   <= mag_b;
            cnt_q   <= w_op ? CW'(32) : CW'(XLEN);
            state_q <= BUSY;
          end
        end
        BUSY: if (FlushE) begin
          state_q <= IDLE;
        end else begin
          quot_q <= step_quot;
          rem_q  <= step_rem;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= pick(q_fin, r_fin, rem_sel_q, w_q);
            state_q  <= DONE;
          end
        end
        DONE: if (FlushE || !StallM) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DivBusyE   = (state_q == BUSY) || ((state_q == IDLE) && DivStartE && !FlushE);
  assign DivDoneE   = (state_q == DONE);
  assign DivResultE = DivDoneE ? result_q : '0;

endmodule

// File: tb/tb_idiv_seq.sv
// Directed bench for idiv_seq (XLEN=64): latency, results, special cases, flush, reset and stall.
module tb_idiv_seq;

  logic        clk = 1'b0;
  logic        reset, DivStartE, FlushE, StallM, W64E;
  logic [2:0]  Funct3E;
  logic [63:0] SrcA, SrcB;
  logic        DivBusyE, DivDoneE;
  logic [63:0] DivResultE;

  int total  = 0;
  int passed = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  always #5 clk = ~clk;

  idiv_seq #(.XLEN(64), .W_SUPPORTED(1'b1)) dut (
    .clk(clk), .reset(reset), .DivStartE(DivStartE), .FlushE(FlushE), .StallM(StallM),
    .Funct3E(Funct3E), .W64E(W64E), .ForwardedSrcAE(SrcA), .ForwardedSrcBE(SrcB),
    .DivBusyE(DivBusyE), .DivDoneE(DivDoneE), .DivResultE(DivResultE)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op at the current cycle t; returns with the DUT in DONE (or after a 200-cycle bound).
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] res);
    int   n;
    logic busy_ok;
    Funct3E = f3; W64E = w; SrcA = a; SrcB = b; DivStartE = 1'b1;
    #1;
    check({tag, " busy@start"}, 64'(DivBusyE), 64'd1);
    tick();
    DivStartE = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!DivDoneE && n < 200) begin
      if (!DivBusyE || DivResultE !== 64'd0) busy_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy/result while busy"}, 64'(busy_ok), 64'd1);
    check({tag, " busy in done"}, 64'(DivBusyE), 64'd0);
    check({tag, " result"}, DivResultE, res);
  endtask

  task automatic release_done(input string tag);
    tick();
    check({tag, " done cleared"}, 64'(DivDoneE), 64'd0);
    check({tag, " result cleared"}, DivResultE, 64'd0);
  endtask

  initial begin
    int seen;
    reset = 1'b0; DivStartE = 1'b0; FlushE = 1'b0; StallM = 1'b0; W64E = 1'b0;
    Funct3E = F_DIV; SrcA = '0; SrcB = '0;
    tick();
    tick();
    check("reset busy", 64'(DivBusyE), 64'd0);
    check("reset done", 64'(DivDoneE), 64'd0);
    check("reset result", DivResultE, 64'd0);
    reset = 1'b1;
    tick();

    run_op("DIV 100/7", F_DIV, 1'b0, 64'd100, 64'd7, 65, 64'd14);
    release_done("DIV 100/7");
    run_op("REM 100/7", F_REM, 1'b0, 64'd100, 64'd7, 65, 64'd2);
    release_done("REM 100/7");
    run_op("DIV -100/7", F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65, 64'hFFFF_FFFF_FFFF_FFF2);
    release_done("DIV -100/7");
    run_op("REM 100/-7", F_REM, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 65, 64'd2);
    release_done("REM 100/-7");
    run_op("DIVW -7/2", F_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    release_done("DIVW -7/2");
    run_op("REMW -7/2", F_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
    release_done("REMW -7/2");
    run_op("DIVU x/0", F_DIVU, 1'b0, 64'h1234, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    release_done("DIVU x/0");
    run_op("REMU x/0", F_REMU, 1'b0, 64'h1234, 64'd0, 1, 64'h1234);
    release_done("REMU x/0");
    run_op("DIV ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
           64'h8000_0000_0000_0000);
    release_done("DIV ovf");
    run_op("REM ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
    release_done("REM ovf");

    // Start coinciding with flush must be ignored.
    Funct3E = F_DIVU; W64E = 1'b0; SrcA = 64'h1234; SrcB = 64'd0;
    DivStartE = 1'b1; FlushE = 1'b1;
    #1;
    check("start+flush busy", 64'(DivBusyE), 64'd0);
    tick();
    DivStartE = 1'b0; FlushE = 1'b0;
    check("start+flush done", 64'(DivDoneE), 64'd0);

    // Flush during cycle t+10 of a BUSY op.
    SrcA = 64'd1000; SrcB = 64'd3; DivStartE = 1'b1;
    tick();
    DivStartE = 1'b0;
    repeat (9) tick();
    check("flush busy before", 64'(DivBusyE), 64'd1);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    check("flush busy after", 64'(DivBusyE), 64'd0);
    seen = 0;
    repeat (80) begin
      if (DivDoneE) seen++;
      tick();
    end
    check("flush no done", 64'(seen), 64'd0);

    // Reset low during cycle t+5.
    SrcA = 64'd1000; SrcB = 64'd3; DivStartE = 1'b1;
    tick();
    DivStartE = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("mid reset busy", 64'(DivBusyE), 64'd0);
    check("mid reset done", 64'(DivDoneE), 64'd0);
    check("mid reset result", DivResultE, 64'd0);
    reset = 1'b1;
    seen = 0;
    repeat (80) begin
      if (DivDoneE || DivBusyE) seen++;
      tick();
    end
    check("mid reset no residue", 64'(seen), 64'd0);

    // Result held for 3 DONE cycles under StallM.
    StallM = 1'b1;
    run_op("DIVU stall", F_DIVU, 1'b0, 64'd1000, 64'd10, 65, 64'd100);
    tick();
    check("stall done c2", 64'(DivDoneE), 64'd1);
    check("stall result c2", DivResultE, 64'd100);
    tick();
    check("stall done c3", 64'(DivDoneE), 64'd1);
    check("stall result c3", DivResultE, 64'd100);
    StallM = 1'b0;
    release_done("DIVU stall");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
